// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   A single pipeline register stage with valid/ready handshaking, used between
//   processor pipeline stages. It carries a control payload and a datapath
//   payload. A flush kills whatever the stage holds and turns it into a
//   bubble. The bubble's control value is CTRL_RST, so downstream logic never
//   sees stale write or branch enables.
//
// Configuration:
//   PIPE_STAGE_SKID_EN (macro)
//     undefined : The stage has a single entry.
//                 in_ready = !out_valid || out_ready || flush (combinational).
//     defined   : The stage has a main entry plus a skid entry.
//                 in_ready = !skid_full || flush, so there is no combinational
//                 path from out_ready to in_ready.
//
// Parameters:
//   DATA_W   : width of the datapath payload (pc, operands, imm, reg indices)
//   CTRL_W   : width of the control payload
//   CTRL_RST : control value loaded on reset and on flush (the bubble)
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst        in   synchronous active-high reset; has priority over flush
//   flush      in   kill the held beat(s); any beat presented now is dropped
//   in_valid   in   upstream presents a beat
//   in_ready   out  stage accepts a beat this cycle
//   in_ctrl    in   upstream control payload  [CTRL_W]
//   in_data    in   upstream datapath payload [DATA_W]
//   out_valid  out  output beat is valid
//   out_ready  in   downstream consumes the output beat (0 = stall)
//   out_ctrl   out  registered control payload (CTRL_RST when not valid)
//   out_data   out  registered datapath payload (left untouched by flush)
//   occupancy  out  number of beats held (0..2 with skid, 0..1 without)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 24,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Main entry. This entry is what the downstream stage sees.
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    logic w_accept;
    logic w_drain;

    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_valid & out_ready;

    assign out_valid = r_valid;
    assign out_ctrl  = r_ctrl;
    assign out_data  = r_data;

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry. It catches a beat that arrives while the main entry is full
    // and stalled.
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    // in_ready depends only on register state, plus flush, so that a discarded
    // beat still counts as consumed upstream.
    assign in_ready  = ~r_skid_valid | flush;
    assign occupancy = {1'b0, r_valid} + {1'b0, r_skid_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_ctrl       <= CTRL_RST;
            r_data       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= CTRL_RST;
            r_skid_data  <= '0;
        end else if (flush) begin
            // r_data is kept so that the pc of the killed instruction stays
            // visible.
            r_valid      <= 1'b0;
            r_ctrl       <= CTRL_RST;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= CTRL_RST;
        end else if (r_skid_valid) begin
            // A full skid entry implies a full main entry, and in_ready is low,
            // so the only event that can occur here is a drain.
            if (w_drain) begin
                r_ctrl       <= r_skid_ctrl;
                r_data       <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= CTRL_RST;
            end
        end else if (w_accept) begin
            if (!r_valid || w_drain) begin
                r_valid <= 1'b1;
                r_ctrl  <= in_ctrl;
                r_data  <= in_data;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_ctrl  <= in_ctrl;
                r_skid_data  <= in_data;
            end
        end else if (w_drain) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
        end
    end
`else
    // Single entry. A stalled full entry blocks upstream, and a draining entry
    // can be refilled in the same cycle.
    assign in_ready  = ~r_valid | out_ready | flush;
    assign occupancy = {1'b0, r_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_ctrl  <= in_ctrl;
            r_data  <= in_data;
        end else if (w_drain) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Purpose:
//   Self-checking bench for pipe_stage_reg.
//
// Structure:
//   - An initial block drives directed vectors and checks their results.
//     After the directed vectors it runs a random handshake phase.
//   - A monitor samples every falling edge. It keeps a queue of accepted
//     beats and compares each beat the DUT delivers against the queue head.
//   - The monitor also checks, every cycle:
//       * occupancy, out_valid and in_ready against the queue depth
//       * the bubble control value whenever out_valid is low
//       * output stability while the stage is stalled
//
// Build:
//   Compile with or without PIPE_STAGE_SKID_EN, matching the DUT build.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int                DATA_W   = 32;
    localparam int                CTRL_W   = 24;
    localparam logic [CTRL_W-1:0] CTRL_RST = '0;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    logic [CTRL_W+DATA_W-1:0] exp_q[$];
    logic                     prev_stall;
    logic [CTRL_W-1:0]        prev_ctrl;
    logic [DATA_W-1:0]        prev_data;
    int                       beats_out = 0;

    initial prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            logic exp_rdy;
`ifdef PIPE_STAGE_SKID_EN
            exp_rdy = flush || (exp_q.size() < 2);
`else
            exp_rdy = flush || (exp_q.size() == 0) || out_ready;
`endif
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (!out_valid)
                chk("bubble_ctrl", 64'(out_ctrl), 64'(CTRL_RST));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_ctrl", 64'(out_ctrl), 64'(prev_ctrl));
            end

            if (flush) begin
                // Every held beat is killed, and the offered beat is dropped.
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_empty", 64'(out_data), 64'hDEAD_BEEF);
                    end else begin
                        logic [CTRL_W+DATA_W-1:0] e;
                        e = exp_q.pop_front();
                        chk("sb_data", 64'(out_data), 64'(e[DATA_W-1:0]));
                        chk("sb_ctrl", 64'(out_ctrl), 64'(e[CTRL_W+DATA_W-1:DATA_W]));
                        beats_out++;
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back({in_ctrl, in_data});
            end

            prev_stall = out_valid && !out_ready && !flush;
            prev_ctrl  = out_ctrl;
            prev_data  = out_data;
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus, followed by a random handshake phase
    // ------------------------------------------------------------------
    int            ordy_pat[6];
    logic [31:0]   beat_val[4];
    logic [31:0]   exp_seq[6];
    logic          exp_rdy_seq[6];
    logic [31:0]   out_log[6];
    logic          rdy_log[6];

    initial begin
        int  k;
        int  wait_cnt;
        logic acc;

        ordy_pat = '{1, 0, 0, 1, 1, 1};
        beat_val = '{32'd1, 32'd2, 32'd3, 32'd4};
        exp_seq  = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4};
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif

        // Reset, with flush also raised: reset must win.
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_data = 32'hAAAA_5555; in_ctrl = 24'hFFFFFF;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'(CTRL_RST));
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);

        // Single beat, one-cycle latency.
        rst = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_data = 32'h100; in_ctrl = 24'h000005; out_ready = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_data", 64'(out_data), 64'h100);
        chk("lat_ctrl", 64'(out_ctrl), 64'h5);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Beats 1..4 with a two-cycle stall after beat 1.
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid  = (k < 4);
            in_data   = (k < 4) ? beat_val[k] : 32'd0;
            in_ctrl   = 24'h10 + 24'(k);
            out_ready = (ordy_pat[c] != 0);
            #1;
            rdy_log[c] = in_ready;
            acc = in_valid && in_ready;
            tick();
            out_log[c] = out_data;
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("stall_accepted", 64'(k), 64'd4);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("stall_seq%0d", c), 64'(out_log[c]), 64'(exp_seq[c]));
            chk($sformatf("stall_rdy%0d", c), 64'(rdy_log[c]), 64'(exp_rdy_seq[c]));
        end
        out_ready = 1'b1;
        tick();
        chk("seq_empty", 64'(out_valid), 64'd0);

        // Flush while holding 0x200, with 0x204 offered in the same cycle.
        in_valid = 1'b1; in_data = 32'h200; in_ctrl = 24'h000007; out_ready = 1'b0;
        tick();
        flush = 1'b1; in_data = 32'h204; in_ctrl = 24'h000009;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctrl", 64'(out_ctrl), 64'(CTRL_RST));
        chk("flush_data", 64'(out_data), 64'h200);
        chk("flush_occ", 64'(occupancy), 64'd0);
        tick();
        tick();
        chk("flush_no_204", 64'(out_valid), 64'd0);
        chk("flush_data_kept", 64'(out_data), 64'h200);

        // Reset and flush together while the stage is full.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h300; in_ctrl = 24'h11;
        tick();
        in_data = 32'h304; in_ctrl = 24'h12;
        tick();
        in_valid = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        chk("full_occ", 64'(occupancy), 64'd2);
`else
        chk("full_occ", 64'(occupancy), 64'd1);
`endif
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        chk("rstfl_data", 64'(out_data), 64'd0);
        chk("rstfl_occ", 64'(occupancy), 64'd0);
        chk("rstfl_valid", 64'(out_valid), 64'd0);
        #1;
        chk("rstfl_in_ready", 64'(in_ready), 64'd1);

        // Random handshakes with occasional flushes. The monitor checks this
        // phase.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(1, 0));
            out_ready = 1'($urandom_range(1, 0));
            flush     = ($urandom_range(49, 0) == 0);
            in_data   = $urandom;
            in_ctrl   = 24'($urandom);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wait_cnt = 0;
        while (occupancy != 2'd0 && wait_cnt < 10) begin
            tick();
            wait_cnt++;
        end
        chk("final_drain_occ", 64'(occupancy), 64'd0);
        tick();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("beats_delivered", 64'(beats_out > 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
